// File: rtl/signed_acc_framer.sv
// Frames a valid/ready sample stream into acc_len-word frames for a signed accumulator.
// Optional frame counter output is enabled with `define ACC_FRAMER_CNT_EN.
module signed_acc_framer #(
  parameter int DIN_WIDTH = 16,
  parameter int LEN_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] acc_len,
  input  logic                 flush,
  input  logic [DIN_WIDTH-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [DIN_WIDTH-1:0] dout,
  output logic                 dout_valid,
  output logic                 acc_done,
  output logic                 busy
`ifdef ACC_FRAMER_CNT_EN
  ,
  output logic [15:0]          frame_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t               state, state_nxt;
  logic [LEN_WIDTH-1:0] len_r;
  logic [LEN_WIDTH-1:0] cnt;
  logic                 first;
  logic                 any;
  logic                 bnd;
  logic                 flush_req;

  logic [LEN_WIDTH-1:0] eff_len;
  logic                 beat;
  logic                 frame_last;
  logic [DIN_WIDTH-1:0] dout_nxt;
  logic                 dout_valid_nxt;
  logic                 acc_done_nxt;

  assign eff_len    = (acc_len == '0) ? LEN_WIDTH'(1) : acc_len;
  assign beat       = s_valid && s_ready;
  assign frame_last = (cnt == len_r - LEN_WIDTH'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (flush_req) state_nxt = any ? FLUSH : IDLE;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_ready        = (state == RUN) && !flush_req;
    busy           = (state != IDLE);
    dout_nxt       = dout;
    dout_valid_nxt = 1'b0;
    acc_done_nxt   = 1'b0;
    if (state == FLUSH) begin
      // Trailing zero word: closes the last frame and clears the accumulator.
      dout_nxt       = '0;
      dout_valid_nxt = 1'b1;
      acc_done_nxt   = 1'b1;
    end else if (beat) begin
      dout_nxt       = s_data;
      dout_valid_nxt = 1'b1;
      acc_done_nxt   = bnd && !first;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_r     <= LEN_WIDTH'(1);
      cnt       <= '0;
      first     <= 1'b0;
      any       <= 1'b0;
      bnd       <= 1'b0;
      flush_req <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_r     <= eff_len;
            cnt       <= '0;
            first     <= 1'b1;
            any       <= 1'b0;
            bnd       <= 1'b0;
            flush_req <= 1'b0;
          end
        end
        RUN: begin
          if (flush) flush_req <= 1'b1;
          if (beat) begin
            first <= 1'b0;
            any   <= 1'b1;
            // acc_len is only sampled at a frame boundary.
            if (frame_last) begin
              cnt   <= '0;
              bnd   <= 1'b1;
              len_r <= eff_len;
            end else begin
              cnt <= cnt + LEN_WIDTH'(1);
              bnd <= 1'b0;
            end
          end
          if (flush_req && !any) begin
            flush_req <= 1'b0;
            cnt       <= '0;
            bnd       <= 1'b0;
          end
        end
        FLUSH: begin
          flush_req <= 1'b0;
          bnd       <= 1'b0;
          cnt       <= '0;
        end
        default: begin
          flush_req <= 1'b0;
          bnd       <= 1'b0;
          cnt       <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      acc_done   <= 1'b0;
    end else begin
      dout       <= dout_nxt;
      dout_valid <= dout_valid_nxt;
      acc_done   <= acc_done_nxt;
    end
  end

`ifdef ACC_FRAMER_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            frame_cnt <= '0;
    else if (acc_done_nxt) frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_signed_acc_framer.sv
// Bench for signed_acc_framer: stream-level model compared every cycle, plus a
// downstream accumulator whose reported frame sums are checked against literals.
module tb_signed_acc_framer;
  localparam int DW = 16;
  localparam int LW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          flush = 1'b0;
  logic          s_valid = 1'b0;
  logic [LW-1:0] acc_len = '0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          acc_done;
  logic          busy;
`ifdef ACC_FRAMER_CNT_EN
  logic [15:0]   frame_cnt;
`endif

  signed_acc_framer #(.DIN_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .acc_len    (acc_len),
    .flush      (flush),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .acc_done   (acc_done),
    .busy       (busy)
`ifdef ACC_FRAMER_CNT_EN
    ,
    .frame_cnt  (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Stream model: tracks position inside the current frame and words since start.
  bit     m_active = 0;
  bit     m_stop = 0;
  bit     m_flush_due = 0;
  int     m_len = 1;
  int     m_pos = 0;
  int     m_words = 0;
  int     m_frames = 0;
  longint m_dout = 0;
  bit     m_valid = 0;
  bit     m_done = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_stop = 0; m_flush_due = 0; m_len = 1; m_pos = 0;
      m_words = 0; m_frames = 0; m_dout = 0; m_valid = 0; m_done = 0;
    end else begin
      m_valid = 0;
      m_done  = 0;
      if (m_flush_due) begin
        m_dout = 0; m_valid = 1; m_done = 1; m_flush_due = 0; m_frames++;
      end else if (m_active) begin
        if (m_stop) begin
          m_active    = 0;
          m_flush_due = (m_words > 0);
        end else begin
          if (s_valid) begin
            m_dout  = longint'($signed(s_data));
            m_valid = 1;
            m_done  = (m_pos == 0) && (m_words > 0);
            if (m_done) m_frames++;
            m_words++;
            m_pos++;
            if (m_pos == m_len) begin
              m_pos = 0;
              m_len = (acc_len == 0) ? 1 : int'(acc_len);
            end
          end
          if (flush) m_stop = 1;
        end
      end else if (start) begin
        m_active = 1; m_stop = 0; m_pos = 0; m_words = 0;
        m_len = (acc_len == 0) ? 1 : int'(acc_len);
      end
    end
  end

  always @(negedge clk) begin
    check("dout_valid", dout_valid, m_valid);
    check("acc_done",   acc_done,   m_done);
    check("dout",       longint'($signed(dout)), m_dout);
    check("s_ready",    s_ready,    m_active && !m_stop);
    check("busy",       busy,       m_active || m_flush_due);
`ifdef ACC_FRAMER_CNT_EN
    check("frame_cnt",  frame_cnt,  m_frames % 65536);
`endif
  end

  // Downstream accumulator, reset together with the framer.
  longint acc = 0;
  longint reports[$];
  int     valid_seen = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc = 0;
    end else if (dout_valid) begin
      valid_seen++;
      if (acc_done) begin
        reports.push_back(acc);
        acc = longint'($signed(dout));
      end else begin
        acc += longint'($signed(dout));
      end
    end
  end

  function automatic longint rep(input int i);
    return (i < reports.size()) ? reports[i] : -999999;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int v);
    s_valid = 1'b1;
    s_data  = DW'(v);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic pulse_start(input int len);
    acc_len = LW'(len);
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check(name, busy, 0);
  endtask

  int base;
  int v0;

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("rst_dout_valid", dout_valid, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_busy", busy, 0);
    #9 rst_n = 1'b1;
    tick();

    // 1: normal framing, acc_len=4, data 1..8
    pulse_start(4);
    for (int i = 1; i <= 8; i++) beat(i);
    tick(); tick();
    check("t1_nreports", reports.size(), 1);
    check("t1_report", rep(0), 10);
    check("t1_acc", acc, 26);

    // 2: flush after a full frame
    pulse_flush();
    wait_idle("t2_idle", 6);
    tick();
    check("t2_nreports", reports.size(), 2);
    check("t2_report", rep(1), 26);
    check("t2_acc", acc, 0);

    // 3: partial frame, then acc_len=0 treated as 1
    base = reports.size();
    pulse_start(4);
    beat(3); beat(-7);
    pulse_flush();
    wait_idle("t3_idle_a", 6);
    tick();
    check("t3_partial", rep(base), -4);
    base = reports.size();
    pulse_start(0);
    beat(10); beat(20); beat(30); beat(40);
    pulse_flush();
    wait_idle("t3_idle_b", 6);
    tick();
    check("t3_nreports", reports.size(), base + 4);
    check("t3_r0", rep(base),     10);
    check("t3_r1", rep(base + 1), 20);
    check("t3_r2", rep(base + 2), 30);
    check("t3_r3", rep(base + 3), 40);

    // 4: flush with no data
    v0 = valid_seen;
    pulse_start(4);
    pulse_flush();
    wait_idle("t4_idle", 2);
    tick();
    check("t4_no_words", valid_seen, v0);

    // 5a: flush together with an accepted beat
    base = reports.size();
    pulse_start(4);
    beat(1); beat(2);
    s_valid = 1'b1; s_data = DW'(3); flush = 1'b1;
    tick();
    s_valid = 1'b0; flush = 1'b0;
    wait_idle("t5a_idle", 6);
    tick();
    check("t5a_report", rep(base), 6);

    // 5b: start during RUN ignored; acc_len 4->2 mid-frame
    base = reports.size();
    pulse_start(4);
    beat(1); beat(2);
    start = 1'b1; acc_len = LW'(1);
    beat(3);
    start = 1'b0; acc_len = LW'(2);
    for (int i = 4; i <= 8; i++) beat(i);
    pulse_flush();
    wait_idle("t5b_idle", 6);
    tick();
    check("t5b_nreports", reports.size(), base + 3);
    check("t5b_r0", rep(base),     10);
    check("t5b_r1", rep(base + 1), 11);
    check("t5b_r2", rep(base + 2), 15);

    // 6: asynchronous reset mid-frame
    pulse_start(4);
    beat(1); beat(2);
    #3 rst_n = 1'b0;
    #1;
    check("t6_dout_valid", dout_valid, 0);
    check("t6_dout", dout, 0);
    check("t6_acc_done", acc_done, 0);
    check("t6_s_ready", s_ready, 0);
    check("t6_busy", busy, 0);
`ifdef ACC_FRAMER_CNT_EN
    check("t6_frame_cnt", frame_cnt, 0);
`endif
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    check("t6_s_ready_after", s_ready, 0);
    check("t6_busy_after", busy, 0);
    check("t6_acc", acc, 0);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
